// File: rtl/maxnet_datapath.sv
// Four-neuron MAXNET winner-take-all datapath, unsigned Q16.16.
// Each step runs FETCH (sum), MULT (inhibition), ADD (ReLU), WRITE (commit) before returning to IDLE.
module maxnet_datapath #(
  parameter logic [31:0] EPS      = 32'h0000_2000,
  parameter int          MAX_ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        step,
  input  logic [31:0] x1_in,
  input  logic [31:0] x2_in,
  input  logic [31:0] x3_in,
  input  logic [31:0] x4_in,
  output logic [31:0] y1,
  output logic [31:0] y2,
  output logic [31:0] y3,
  output logic [31:0] y4,
  output logic        busy,
  output logic        write_reg,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  iter_cnt,
  output logic [2:0]  state_dbg
);

  // Handshake: step is a one-cycle request sampled only in IDLE while done, timeout and init are low;
  // write_reg is a one-cycle pulse in the cycle y1..y4 first show the committed values.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MULT  = 3'd2,
    S_ADD   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [3:0][31:0] y_q, y_d;
  logic [3:0][49:0] p_q, p_d;
  logic [3:0][31:0] n_q, n_d;
  logic [33:0]      s_q, s_d;
  logic             busy_q, busy_d;
  logic             write_reg_q, write_reg_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       iter_cnt_q, iter_cnt_d;
  // Low on the first edge after reset release so a step held across release is dropped.
  logic             run_q, run_d;
  logic             win_found;

  always_comb begin
    win_found = ($countones({n_q[3] != '0, n_q[2] != '0, n_q[1] != '0, n_q[0] != '0}) <= 1);
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    p_d         = p_q;
    n_d         = n_q;
    s_d         = s_q;
    write_reg_d = 1'b0;
    done_d      = done_q;
    timeout_d   = timeout_q;
    iter_cnt_d  = iter_cnt_q;
    run_d       = 1'b1;

    if (init) begin
      state_d    = S_IDLE;
      y_d        = {x4_in, x3_in, x2_in, x1_in};
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      iter_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (step && run_q && !done_q && !timeout_q) state_d = S_FETCH;
        end
        S_FETCH: begin
          s_d     = 34'(y_q[0]) + 34'(y_q[1]) + 34'(y_q[2]) + 34'(y_q[3]);
          state_d = S_MULT;
        end
        S_MULT: begin
          // S - y_i is never negative since S contains y_i.
          for (int i = 0; i < 4; i++) begin
            p_d[i] = 50'((66'(EPS) * 66'(s_q - 34'(y_q[i]))) >> 16);
          end
          state_d = S_ADD;
        end
        S_ADD: begin
          for (int i = 0; i < 4; i++) begin
            n_d[i] = ({18'd0, y_q[i]} > p_q[i]) ? (y_q[i] - p_q[i][31:0]) : 32'd0;
          end
          state_d = S_WRITE;
        end
        S_WRITE: begin
          y_d         = n_q;
          write_reg_d = 1'b1;
          iter_cnt_d  = (iter_cnt_q == 8'hFF) ? 8'hFF : iter_cnt_q + 8'd1;
          done_d      = win_found;
          timeout_d   = (({1'b0, iter_cnt_q} + 9'd1) == 9'(MAX_ITER)) && !win_found;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      p_q         <= '0;
      n_q         <= '0;
      s_q         <= '0;
      busy_q      <= 1'b0;
      write_reg_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      iter_cnt_q  <= 8'd0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      p_q         <= p_d;
      n_q         <= n_d;
      s_q         <= s_d;
      busy_q      <= busy_d;
      write_reg_q <= write_reg_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      iter_cnt_q  <= iter_cnt_d;
      run_q       <= run_d;
    end
  end

  assign y1        = y_q[0];
  assign y2        = y_q[1];
  assign y3        = y_q[2];
  assign y4        = y_q[3];
  assign busy      = busy_q;
  assign write_reg = write_reg_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign iter_cnt  = iter_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_maxnet_datapath.sv
// Directed bench for maxnet_datapath: dut_a uses MAX_ITER=16, dut_b uses MAX_ITER=4, inputs shared.
module tb_maxnet_datapath;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        init  = 1'b0;
  logic        step  = 1'b0;
  logic [31:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;

  logic [31:0] ya1, ya2, ya3, ya4, yb1, yb2, yb3, yb4;
  logic        busy_a, wr_a, done_a, to_a, busy_b, wr_b, done_b, to_b;
  logic [7:0]  it_a, it_b;
  logic [2:0]  st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic seen;
  logic [31:0] exp_y1 [4];
  logic [31:0] exp_y2 [4];
  logic [31:0] exp_yb [3];

  maxnet_datapath #(.EPS(32'h0000_2000), .MAX_ITER(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .init(init), .step(step),
    .x1_in(x1), .x2_in(x2), .x3_in(x3), .x4_in(x4),
    .y1(ya1), .y2(ya2), .y3(ya3), .y4(ya4),
    .busy(busy_a), .write_reg(wr_a), .done(done_a), .timeout(to_a),
    .iter_cnt(it_a), .state_dbg(st_a)
  );

  maxnet_datapath #(.EPS(32'h0000_2000), .MAX_ITER(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .init(init), .step(step),
    .x1_in(x1), .x2_in(x2), .x3_in(x3), .x4_in(x4),
    .y1(yb1), .y2(yb2), .y3(yb3), .y4(yb4),
    .busy(busy_b), .write_reg(wr_b), .done(done_b), .timeout(to_b),
    .iter_cnt(it_b), .state_dbg(st_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_init(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; x4 = d;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // lat = edges after the sampling edge until write_reg is seen; 10 means no commit.
  task automatic do_step(input logic sel_b, output int l);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    l = 0;
    while (!(sel_b ? wr_b : wr_a) && l < 10) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    exp_y1 = '{32'h0000_D800, 32'h0000_D140, 32'h0000_CDE0, 32'h0000_CDC5};
    exp_y2 = '{32'h0000_3600, 32'h0000_1B00, 32'h0000_00D8, 32'h0000_0000};
    exp_yb = '{32'h0000_6400, 32'h0000_3E80, 32'h0000_2710};

    // reset state, then release with step held high
    step = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_y_a", {ya1, ya2, ya3, ya4}, 128'd0);
    check("rst_flags_a", {busy_a, wr_a, done_a, to_a, it_a, st_a}, 128'd0);
    check("rst_y_b", {yb1, yb2, yb3, yb4}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("release_step_dropped", {busy_a, st_a}, 128'd0);

    // first iteration of the reference vector
    do_init(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000);
    check("init_y", {ya1, ya2, ya3, ya4},
          {32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000});
    do_step(1'b0, lat);
    check("latency", lat, 4);
    check("iter1_y", {ya1, ya2, ya3, ya4},
          {32'h0000_E400, 32'h0000_5400, 32'h0000_0C00, 32'h0000_0000});
    check("iter1_flags", {busy_a, done_a, to_a, it_a}, {1'b0, 1'b0, 1'b0, 8'd1});
    @(negedge clk);
    check("write_reg_pulse", wr_a, 1'b0);

    // continue to convergence
    for (int k = 0; k < 4; k++) begin
      do_step(1'b0, lat);
      check("conv_lat", lat, 4);
      check("conv_y", {ya1, ya2, ya3, ya4}, {exp_y1[k], exp_y2[k], 64'd0});
    end
    check("conv_done", {done_a, to_a, it_a}, {1'b1, 1'b0, 8'd5});
    do_step(1'b0, lat);
    check("done_step_ignored", {lat[7:0], busy_a, it_a, ya1},
          {8'd10, 1'b0, 8'd5, 32'h0000_CDC5});

    // timeout with equal activations on the MAX_ITER=4 instance
    do_init(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    do_step(1'b1, lat);
    check("eq_iter1_y", {yb1, yb2, yb3, yb4}, {4{32'h0000_A000}});
    for (int k = 0; k < 3; k++) begin
      check("eq_no_timeout_yet", to_b, 1'b0);
      do_step(1'b1, lat);
      check("eq_y", {yb1, yb2, yb3, yb4}, {4{exp_yb[k]}});
    end
    check("timeout_flags", {to_b, done_b, it_b}, {1'b1, 1'b0, 8'd4});
    do_step(1'b1, lat);
    check("timeout_step_ignored", {lat[7:0], busy_b, it_b}, {8'd10, 1'b0, 8'd4});

    // single nonzero neuron
    do_init(32'h0, 32'h0, 32'h0000_7000, 32'h0);
    do_step(1'b0, lat);
    check("single_y", {ya1, ya2, ya3, ya4}, {64'd0, 32'h0000_7000, 32'd0});
    check("single_done", {done_a, it_a}, {1'b1, 8'd1});

    // init during MULT aborts the iteration
    do_init(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("in_mult", st_a, 3'd2);
    x1 = 32'h0000_1111; x2 = 32'h0000_2222; x3 = 32'h0000_3333; x4 = 32'h0000_4444;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("abort_y", {ya1, ya2, ya3, ya4},
          {32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444});
    check("abort_flags", {busy_a, wr_a, it_a, st_a}, 128'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | wr_a;
    end
    check("abort_no_write", seen, 1'b0);

    // asynchronous reset during ADD
    do_init(32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (2) @(negedge clk);
    check("in_add", st_a, 3'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", {ya1, ya2, ya3, ya4}, 128'd0);
    check("async_rst_flags", {busy_a, wr_a, done_a, to_a, it_a, st_a}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {busy_a, wr_a, st_a, ya1}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
